// File: rtl/regfile_alu_pipe.sv
// Two-stage register file + ALU: stage 1 reads/latches operands, stage 2 executes,
// writes back and latches flags. Forwarding lets back-to-back dependent ops issue without a bubble.
module regfile_alu_pipe #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [AW-1:0]    SA,
    input  logic [AW-1:0]    SB,
    input  logic [AW-1:0]    DA,
    input  logic             W,
    input  logic [WIDTH-1:0] K,
    input  logic             B_SEL,
    input  logic [4:0]       FS,
    input  logic             C_in,
    input  logic             SET_FLAGS,
    input  logic             stall,
    output logic [WIDTH-1:0] F,
    output logic             out_valid,
    output logic [3:0]       status,
    input  logic [AW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [AW-1:0] ZADDR = AW'(NREGS - 1);
    localparam bit HAS_ZR = (ZERO_REG != 0);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [AW-1:0]    da;
        logic             w;
        logic [4:0]       fs;
        logic             cin;
        logic             setf;
    } s1_t;

    logic [WIDTH-1:0] rf [NREGS];
    s1_t              s1;
    logic             s1_valid;

    logic [WIDTH-1:0] alu_a, alu_b, res;
    logic [WIDTH:0]   sum;
    logic             cf, vf;
    logic [3:0]       flags;
    logic             wb_en;
    logic [WIDTH-1:0] op_a, reg_b, op_b;

    always_comb begin
        alu_a = s1.fs[1] ? ~s1.a : s1.a;
        alu_b = s1.fs[0] ? ~s1.b : s1.b;
        sum   = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, s1.cin};
        res   = '0;
        cf    = 1'b0;
        vf    = 1'b0;
        case (s1.fs[4:2])
            3'b000: res = alu_a & alu_b;
            3'b001: res = alu_a | alu_b;
            3'b010: begin
                res = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                vf  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (res[WIDTH-1] != alu_a[WIDTH-1]);
            end
            3'b011: res = alu_a ^ alu_b;
            3'b100: res = s1.a << s1.b[SHW-1:0];
            3'b101: res = s1.a >> s1.b[SHW-1:0];
            default: res = '0;
        endcase
        flags = {vf, cf, res[WIDTH-1], res == '0};
    end

    assign wb_en = s1_valid && s1.w && !(HAS_ZR && s1.da == ZADDR);

    // Operand read: zero register wins over a forwarded write-back result.
    always_comb begin
        op_a = rf[SA];
        if (wb_en && s1.da == SA) op_a = res;
        if (HAS_ZR && SA == ZADDR) op_a = '0;
        reg_b = rf[SB];
        if (wb_en && s1.da == SB) reg_b = res;
        if (HAS_ZR && SB == ZADDR) reg_b = '0;
        op_b = B_SEL ? K : reg_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            s1        <= '0;
            s1_valid  <= 1'b0;
            F         <= '0;
            out_valid <= 1'b0;
            status    <= '0;
        end else if (!stall) begin
            s1_valid  <= in_valid;
            if (in_valid) begin
                s1.a    <= op_a;
                s1.b    <= op_b;
                s1.da   <= DA;
                s1.w    <= W;
                s1.fs   <= FS;
                s1.cin  <= C_in;
                s1.setf <= SET_FLAGS;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                F <= res;
                if (s1.setf) status <= flags;
            end
            if (wb_en) rf[s1.da] <= res;
        end
    end

    assign dbg_data = (HAS_ZR && dbg_sel == ZADDR) ? '0 : rf[dbg_sel];
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Directed test-plan sequences plus randomized micro-ops checked against an
// in-order architectural model (each op executes completely at issue).
module tb_regfile_alu_pipe;
    localparam int WIDTH = 64;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int ZR    = 31;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [AW-1:0]    SA = '0, SB = '0, DA = '0, dbg_sel = '0;
    logic             W = 1'b0, B_SEL = 1'b0, C_in = 1'b0, SET_FLAGS = 1'b0, stall = 1'b0;
    logic [WIDTH-1:0] K = '0;
    logic [4:0]       FS = '0;
    logic [WIDTH-1:0] F, dbg_data;
    logic             out_valid;
    logic [3:0]       status;

    always #5 clock = ~clock;

    regfile_alu_pipe #(.WIDTH(WIDTH), .NREGS(NREGS), .ZERO_REG(1)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .SA(SA), .SB(SB), .DA(DA),
        .W(W), .K(K), .B_SEL(B_SEL), .FS(FS), .C_in(C_in), .SET_FLAGS(SET_FLAGS),
        .stall(stall), .F(F), .out_valid(out_valid), .status(status),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit         v;
        logic [63:0] f;
        logic [3:0]  fl;
        bit          setf;
    } slot_t;

    logic [63:0] mreg [NREGS];
    logic [63:0] f_exp;
    logic [3:0]  st_exp;
    slot_t       sl1, sl2;

    function automatic logic [63:0] mrd(input int x);
        return (x == ZR) ? 64'd0 : mreg[x];
    endfunction

    task automatic ref_exec(output logic [63:0] r, output logic [3:0] fl);
        logic [63:0] opa, opb, a, b;
        logic [64:0] u;
        logic signed [65:0] s;
        bit c, v;
        opa = mrd(int'(SA));
        opb = B_SEL ? K : mrd(int'(SB));
        a = FS[1] ? ~opa : opa;
        b = FS[0] ? ~opb : opb;
        c = 0; v = 0;
        case (FS[4:2])
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                u = {1'b0, a} + {1'b0, b} + {64'd0, C_in};
                s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, C_in});
                r = u[63:0];
                c = u[64];
                v = (s != $signed({{2{r[63]}}, r}));
            end
            3'd3: r = a ^ b;
            3'd4: r = opa << opb[5:0];
            3'd5: r = opa >> opb[5:0];
            default: r = 64'd0;
        endcase
        fl = {v, c, r[63], r == 64'd0};
    endtask

    task automatic step();
        logic [63:0] r;
        logic [3:0]  fl;
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mreg[i] = 64'd0;
            sl1.v = 0; sl2.v = 0; f_exp = 64'd0; st_exp = 4'd0;
        end else if (!stall) begin
            sl2 = sl1;
            if (sl2.v) begin
                f_exp = sl2.f;
                if (sl2.setf) st_exp = sl2.fl;
            end
            if (in_valid) begin
                ref_exec(r, fl);
                if (W && int'(DA) != ZR) mreg[DA] = r;
                sl1.v = 1; sl1.f = r; sl1.fl = fl; sl1.setf = SET_FLAGS;
            end else sl1.v = 0;
        end
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, sl2.v});
        chk("F", F, f_exp);
        chk("status", {60'd0, status}, {60'd0, st_exp});
    endtask

    task automatic issue(input int sa, input int sb, input int da, input bit w, input logic [63:0] k,
                         input bit bsel, input logic [4:0] fs, input bit cin, input bit setf);
        SA = AW'(sa); SB = AW'(sb); DA = AW'(da); W = w; K = k; B_SEL = bsel;
        FS = fs; C_in = cin; SET_FLAGS = setf; stall = 0; in_valid = 1;
        step();
    endtask

    task automatic idle();
        in_valid = 0; stall = 0;
        step();
    endtask

    task automatic dbg(input string tag, input int sel, input logic [63:0] exp);
        dbg_sel = AW'(sel);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    initial begin
        step(); step();
        dbg("rst_dbg", 3, 64'd0);
        reset = 0;

        // load immediate 5 into r0..r7
        for (int i = 0; i < 8; i++) issue(ZR, 0, i, 1, 64'd5, 1, 5'b01000, 0, 1);
        chk("ld_f", F, 64'd5);
        idle(); idle();
        chk("ld_st", {60'd0, status}, 64'd0);
        for (int i = 0; i < 8; i++) dbg("ld_r", i, 64'd5);

        // dependent chain through forwarding
        issue(ZR, 0, 1, 1, 64'd3, 1, 5'b01000, 0, 0);
        dbg("dbg_old", 1, 64'd5);
        issue(1, 1, 2, 1, 64'd0, 0, 5'b01000, 0, 0);
        idle();
        chk("chain_f", F, 64'd6);
        idle();
        dbg("chain_r2", 2, 64'd6);

        // carry/zero flags, then same op without flag update
        issue(ZR, 0, 1, 1, '1, 1, 5'b01000, 0, 0);
        issue(1, 0, 4, 1, 64'd1, 1, 5'b01000, 0, 1);
        idle();
        chk("flg_f", F, 64'd0);
        chk("flg_st", {60'd0, status}, 64'h5);
        issue(1, 0, 4, 1, 64'd1, 1, 5'b01000, 0, 0);
        idle(); idle();
        chk("flg_hold", {60'd0, status}, 64'h5);

        // subtract with signed overflow
        issue(ZR, 0, 3, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 5'b01000, 0, 0);
        issue(3, 0, 5, 1, 64'h8000_0000_0000_0000, 1, 5'b01001, 1, 1);
        idle();
        chk("sub_f", F, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub_st", {60'd0, status}, 64'hA);
        idle();

        // zero register, including immediately after a write to it
        issue(ZR, 0, ZR, 1, 64'd9, 1, 5'b01000, 0, 0);
        issue(ZR, ZR, 6, 1, 64'd0, 0, 5'b01000, 0, 1);
        chk("zr_f", F, 64'd9);
        idle();
        chk("zr_rd", F, 64'd0);
        chk("zr_st", {60'd0, status}, 64'h1);
        dbg("zr_dbg", ZR, 64'd0);

        // shifts
        issue(0, 0, 7, 1, 64'd4, 1, 5'b10000, 0, 0);
        issue(7, 0, 8, 1, 64'd4, 1, 5'b10100, 0, 0);
        chk("lsl", F, 64'd80);
        idle();
        chk("lsr", F, 64'd5);
        idle();

        // stall freezes the pipe; in_valid ignored meanwhile
        issue(ZR, 0, 9, 1, 64'd42, 1, 5'b01000, 0, 0);
        stall = 1; in_valid = 1; K = 64'd99; DA = 5'd10;
        for (int i = 0; i < 3; i++) step();
        chk("stall_hold", F, 64'd5);
        idle();
        chk("stall_done", F, 64'd42);
        idle();
        dbg("stall_r9", 9, 64'd42);
        dbg("stall_r10", 10, 64'd0);

        // reset discards an in-flight write
        issue(ZR, 0, 6, 1, 64'd77, 1, 5'b01000, 0, 1);
        reset = 1; in_valid = 0;
        step();
        reset = 0;
        dbg("rst_r6", 6, 64'd0);
        idle();
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_st", {60'd0, status}, 64'd0);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            stall     = ($urandom_range(0, 4) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            SA        = AW'($urandom); SB = AW'($urandom); DA = AW'($urandom);
            W         = ($urandom_range(0, 4) != 0);
            B_SEL     = $urandom_range(0, 1);
            FS        = 5'($urandom);
            C_in      = $urandom_range(0, 1);
            SET_FLAGS = $urandom_range(0, 1);
            K         = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) K = 64'($urandom_range(0, 70));
            step();
        end
        reset = 0;
        idle(); idle(); idle();
        for (int i = 0; i < NREGS; i++) dbg("rand_reg", i, mrd(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
